// File: rtl/uplink_capture_pkg.sv
// Shared types and default widths for the uplink capture-window controller.
package uplink_capture_pkg;

  localparam int UC_DATA_W = 234;
  localparam int UC_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } capture_state_t;

endpackage

// File: rtl/uplink_capture_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uplink_capture_ctrl.sv
// Capture-window controller gating lpGBT uplink frames into the dataframe FIFO.
// Optional macro UPLINK_CAPTURE_FEC_DROP_EN: FEC-corrected frames are rejected and counted.
module uplink_capture_ctrl
  import uplink_capture_pkg::*;
#(
  parameter int DATA_W = UC_DATA_W,
  parameter int CNT_W  = UC_CNT_W
) (
  input  logic              clk40_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] uplinkUserData_i,
  input  logic              uplinkrdy_i,
  input  logic              uplinkFEC_i,
  input  logic              arm_i,
  input  logic              trig_i,
  input  logic [CNT_W-1:0]  frame_count_i,
  input  logic              suppress_idle_i,
  input  logic              fifo_full_i,
  output logic [DATA_W-1:0] fifo_din_o,
  output logic              fifo_wr_en_o,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  captured_cnt_o,
  output logic [CNT_W-1:0]  dropped_cnt_o,
`ifdef UPLINK_CAPTURE_FEC_DROP_EN
  output logic [CNT_W-1:0]  fec_drop_cnt_o,
`endif
  output logic              done_o
);

  capture_state_t   state;
  logic             arm_q;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] win_next;
  logic [CNT_W-1:0] len_eff;
  logic             not_idle;
  logic             qual;
  logic             arm_edge;
  logic             cnt_clr;
  logic             start;
  logic             take;
  logic             wr;
  logic             drop;
  logic             win_hit;

  assign not_idle = !(suppress_idle_i && (uplinkUserData_i == '0));

`ifdef UPLINK_CAPTURE_FEC_DROP_EN
  logic fec_inc;
  assign qual    = uplinkrdy_i && not_idle && !uplinkFEC_i;
  assign fec_inc = (state == CAPTURE) && arm_i && uplinkrdy_i && uplinkFEC_i;

  sat_counter #(.W(CNT_W)) u_fec_cnt (
    .clk (clk40_i),
    .rst (rst_i),
    .clr (cnt_clr),
    .inc (fec_inc),
    .cnt (fec_drop_cnt_o)
  );
`else
  logic unused_fec;
  assign unused_fec = uplinkFEC_i;
  assign qual       = uplinkrdy_i && not_idle;
`endif

  assign arm_edge = arm_i && !arm_q;
  assign cnt_clr  = (state == IDLE) && arm_edge;

  // The trigger-cycle frame is itself the first frame of the window.
  assign start = (state == ARMED) && arm_i && trig_i && qual;
  assign take  = start || ((state == CAPTURE) && arm_i && qual);
  assign wr    = take && !fifo_full_i;
  assign drop  = take && fifo_full_i;

  // Compare against the window count this frame produces, so the last frame is still written.
  assign win_next = (&win_cnt) ? win_cnt : win_cnt + 1'b1;
  assign len_eff  = (state == ARMED) ? frame_count_i : len_r;
  assign win_hit  = (len_eff != '0) && (win_next == len_eff);

  sat_counter #(.W(CNT_W)) u_win_cnt (
    .clk (clk40_i),
    .rst (rst_i),
    .clr (cnt_clr),
    .inc (take),
    .cnt (win_cnt)
  );

  sat_counter #(.W(CNT_W)) u_cap_cnt (
    .clk (clk40_i),
    .rst (rst_i),
    .clr (cnt_clr),
    .inc (wr),
    .cnt (captured_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk (clk40_i),
    .rst (rst_i),
    .clr (cnt_clr),
    .inc (drop),
    .cnt (dropped_cnt_o)
  );

  always_ff @(posedge clk40_i) begin
    if (rst_i) begin
      state        <= IDLE;
      arm_q        <= 1'b0;
      len_r        <= '0;
      fifo_din_o   <= '0;
      fifo_wr_en_o <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      arm_q        <= arm_i;
      fifo_wr_en_o <= wr;
      done_o       <= 1'b0;
      if (wr) begin
        fifo_din_o <= uplinkUserData_i;
      end
      if (start) begin
        len_r <= frame_count_i;
      end
      if (!arm_i) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (!arm_q) begin
              state <= ARMED;
            end
          end
          ARMED, CAPTURE: begin
            if (take) begin
              if (win_hit) begin
                state  <= DONE;
                done_o <= 1'b1;
              end else begin
                state <= CAPTURE;
              end
            end
          end
          DONE: begin
            done_o <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_uplink_capture_ctrl.sv
// Self-checking bench for uplink_capture_ctrl: directed windows followed by randomized traffic.
module tb_uplink_capture_ctrl;

  localparam int DW   = 234;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data;
  logic          rdy;
  logic          fec;
  logic          arm;
  logic          trig;
  logic [CW-1:0] fc;
  logic          sup;
  logic          full;
  logic [DW-1:0] din;
  logic          wr_en;
  logic [1:0]    state;
  logic [CW-1:0] cap_cnt;
  logic [CW-1:0] drop_cnt;
  logic          done;
`ifdef UPLINK_CAPTURE_FEC_DROP_EN
  logic [CW-1:0] fec_cnt;
`endif

  uplink_capture_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk40_i          (clk),
    .rst_i            (rst),
    .uplinkUserData_i (data),
    .uplinkrdy_i      (rdy),
    .uplinkFEC_i      (fec),
    .arm_i            (arm),
    .trig_i           (trig),
    .frame_count_i    (fc),
    .suppress_idle_i  (sup),
    .fifo_full_i      (full),
    .fifo_din_o       (din),
    .fifo_wr_en_o     (wr_en),
    .state_o          (state),
    .captured_cnt_o   (cap_cnt),
    .dropped_cnt_o    (drop_cnt),
`ifdef UPLINK_CAPTURE_FEC_DROP_EN
    .fec_drop_cnt_o   (fec_cnt),
`endif
    .done_o           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: window bookkeeping in plain integers.
  int            m_phase;  // 0 idle, 1 armed, 2 capturing, 3 done
  bit            m_armq;
  int            m_len, m_win, m_cap, m_drop, m_fec;
  bit            m_wr, m_done;
  logic [DW-1:0] m_din;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic take_frame();
    m_win = sat_inc(m_win);
    if (full) begin
      m_drop = sat_inc(m_drop);
    end else begin
      m_cap = sat_inc(m_cap);
      m_wr  = 1'b1;
      m_din = data;
    end
    m_phase = (m_len != 0 && m_win == m_len) ? 3 : 2;
  endtask

  task automatic model_update();
    bit qual;
    qual = rdy && !(sup && data == '0);
`ifdef UPLINK_CAPTURE_FEC_DROP_EN
    qual = qual && !fec;
`endif
    m_wr = 1'b0;
    if (rst) begin
      m_phase = 0; m_armq = 1'b0; m_len = 0; m_win = 0;
      m_cap = 0; m_drop = 0; m_fec = 0; m_din = '0; m_done = 1'b0;
    end else begin
      if (!arm) begin
        m_phase = 0;
      end else if (m_phase == 0) begin
        if (!m_armq) begin
          m_phase = 1; m_win = 0; m_cap = 0; m_drop = 0; m_fec = 0;
        end
      end else if (m_phase == 1) begin
        if (trig && qual) begin
          m_len = int'(fc);
          take_frame();
        end
      end else if (m_phase == 2) begin
`ifdef UPLINK_CAPTURE_FEC_DROP_EN
        if (rdy && fec) m_fec = sat_inc(m_fec);
`endif
        if (qual) take_frame();
      end
      m_armq = arm;
      m_done = (m_phase == 3);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_update();
    chk("state", 256'(state), 256'(m_phase));
    chk("wr_en", 256'(wr_en), 256'(m_wr));
    chk("din", 256'(din), 256'(m_din));
    chk("captured", 256'(cap_cnt), 256'(m_cap));
    chk("dropped", 256'(drop_cnt), 256'(m_drop));
    chk("done", 256'(done), 256'(m_done));
`ifdef UPLINK_CAPTURE_FEC_DROP_EN
    chk("fec_drop", 256'(fec_cnt), 256'(m_fec));
`endif
  endtask

  task automatic cyc(input bit a, input bit t, input bit r, input bit f,
                     input int len, input logic [DW-1:0] d);
    rst = 1'b0; arm = a; trig = t; rdy = r; full = f; fc = CW'(len); data = d; fec = 1'b0;
    step();
  endtask

  function automatic logic [DW-1:0] rand_frame();
    logic [DW-1:0] v;
    v = '0;
    if ($urandom_range(3) == 0) return v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    rst = 1'b1; arm = 1'b0; trig = 1'b0; rdy = 1'b0; full = 1'b0;
    fc = '0; data = '0; sup = 1'b0; fec = 1'b0;
    step();
    step();

    // Window of 4 over frames 1..6.
    cyc(1, 0, 0, 0, 0, '0);
    for (int k = 1; k <= 6; k++) cyc(1, k == 1, 1, 0, 4, DW'(k));
    cyc(0, 0, 0, 0, 0, '0);

    // Continuous window of 10, abort, re-arm clears the counters.
    cyc(1, 0, 0, 0, 0, '0);
    for (int k = 1; k <= 10; k++) cyc(1, k == 1, 1, 0, 0, DW'(k + 16));
    cyc(0, 0, 1, 0, 0, DW'(99));
    cyc(0, 0, 0, 0, 0, '0);
    cyc(1, 0, 0, 0, 0, '0);
    cyc(0, 0, 0, 0, 0, '0);

    // Window of 5 with FIFO full on frames 2-3.
    cyc(1, 0, 0, 0, 0, '0);
    for (int k = 1; k <= 5; k++) cyc(1, k == 1, 1, (k == 2 || k == 3), 5, DW'(k + 32));
    cyc(1, 1, 1, 0, 5, DW'(40));
    cyc(0, 0, 0, 0, 0, '0);

    // Idle suppression: zero frames neither qualify nor trigger.
    sup = 1'b1;
    cyc(1, 0, 0, 0, 0, '0);
    cyc(1, 1, 1, 0, 3, '0);
    cyc(1, 1, 1, 0, 3, DW'(8'hA));
    cyc(1, 0, 1, 0, 3, '0);
    cyc(1, 0, 1, 0, 3, DW'(8'hB));
    cyc(1, 0, 1, 0, 3, '0);
    cyc(1, 0, 1, 0, 3, DW'(8'hC));
    cyc(0, 0, 0, 0, 0, '0);
    sup = 1'b0;

    // Window of 8 aborted after frame 3.
    cyc(1, 0, 0, 0, 0, '0);
    for (int k = 1; k <= 3; k++) cyc(1, k == 1, 1, 0, 8, DW'(k + 48));
    cyc(0, 0, 1, 0, 8, DW'(52));
    cyc(0, 0, 0, 0, 0, '0);

    // Saturation: 20 drops then 20 writes in continuous mode.
    cyc(1, 0, 0, 0, 0, '0);
    for (int k = 0; k < 20; k++) cyc(1, k == 0, 1, 1, 0, DW'(k + 64));
    for (int k = 0; k < 20; k++) cyc(1, 0, 1, 0, 0, DW'(k + 96));
    cyc(0, 0, 0, 0, 0, '0);

    // Reset in the middle of a window.
    cyc(1, 0, 0, 0, 0, '0);
    cyc(1, 1, 1, 0, 6, DW'(7));
    rst = 1'b1;
    step();
    cyc(1, 0, 1, 0, 0, DW'(9));

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      rst  = ($urandom_range(299) == 0);
      arm  = ($urandom_range(29) != 0);
      trig = ($urandom_range(4) == 0);
      rdy  = ($urandom_range(6) != 0);
      full = ($urandom_range(4) == 0);
      sup  = ($urandom_range(2) == 0);
      fec  = ($urandom_range(7) == 0);
      fc   = ($urandom_range(5) == 0) ? CW'($urandom_range(CMAX)) : CW'($urandom_range(6));
      data = rand_frame();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
